systolic_input_skewer: RTL
==========================

# systolic_input_skewer

Upstream feeder for the SIZE×SIZE systolic matrix-multiply array. It accepts SIZE operand vector pairs (one A vector and one B vector per beat) over a valid/ready handshake and buffers them. It then streams them to the array's flat `a`/`b` input buses as a diagonal wavefront: lane k is delayed k cycles and zero-padded outside its window. It brackets each run with a one-cycle array clear pulse before streaming and a done pulse after the drain.

## Interface
- SIZE, 4, array dimension; lane count and vectors per matrix
- I_BITS, 8, operand element width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat
- i_a_vec  in  SIZE*I_BITS  A vector; element k at bits [k*I_BITS +: I_BITS]
- i_b_vec  in  SIZE*I_BITS  B vector; same packing
- o_a_full  out  SIZE*I_BITS  skewed A lanes to the array
- o_b_full  out  SIZE*I_BITS  skewed B lanes to the array
- o_stream_valid  out  1  high while wavefront or drain data is on o_a_full/o_b_full
- o_clear  out  1  one-cycle pulse; top level ORs it into the array reset
- o_done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD, CLEAR, STREAM, DRAIN, DONE.
- IDLE/LOAD: o_ready=1.
  - Each cycle with i_valid && o_ready writes beat j (0..SIZE-1) into buffers bufA[j] and bufB[j].
  - The first beat moves IDLE→LOAD.
  - Beat SIZE-1 moves to CLEAR.
- CLEAR: one cycle. o_ready=0, o_clear=1, outputs zero.
- STREAM: step counter t runs 0..2*SIZE-2.
  - For lane k, d=t-k.
  - If 0≤d<SIZE: lane k of o_a_full is bufA[d] element k, and lane k of o_b_full is bufB[d] element k.
  - Otherwise lane k is 0.
  - After t=2*SIZE-2, go to DRAIN.
- DRAIN: SIZE cycles of all-zero lanes with o_stream_valid=1, letting the last wavefront propagate through the array. Then go to DONE.
- DONE: one cycle, o_done=1, then IDLE.
- In CLEAR/STREAM/DRAIN/DONE, o_ready=0 and i_valid is ignored. No beat is lost or stored.
- Arithmetic: no data arithmetic; elements pass unchanged. Counters are $clog2(2*SIZE) bits wide. The beat index is $clog2(SIZE) bits (minimum 1).

## Timing
- Reset values: all outputs 0, except o_ready=1 once reset deasserts (state IDLE). Buffers are cleared to 0 and counters to 0.
- Reset mid-run:
  - Asynchronously forces IDLE and zeroes all outputs immediately.
  - A partially loaded matrix is discarded.
  - No o_done is issued.
- o_a_full, o_b_full, o_stream_valid, o_clear and o_done are registered.
- The state entered at edge n produces its outputs from edge n+1.
- Latency:
  - Last accepted beat at edge e gives o_clear high during cycle e+1..e+2.
  - STREAM step t=0 is on the outputs one cycle after o_clear.
- Run length after the last beat: 1 clear + (2*SIZE-1) stream + SIZE drain + 1 done cycle. SIZE=4 gives 13 cycles.
- Back-to-back runs: the next beat can be accepted the cycle after o_done is seen (IDLE, o_ready=1).

## Configuration
- SYSTOLIC_SKEWER_DRAIN_EN
  - Defined: the DRAIN state exists as described.
  - Undefined: STREAM goes directly to DONE. o_stream_valid drops after the last wavefront step, and run length is 2*SIZE+1 cycles. The consumer relies on the array's internal counters for completion.

## Structure
- Shared package:
  - state enum encoding (6 states, 3 bits)
  - stream length constant 2*SIZE-1
  - drain length constant SIZE
- Sub-module: systolic_lane_select, one instance per lane k. It takes step t and the buffered column k and returns the element or 0 under the window rule. The top level holds the FSM, buffers and counters.

## Test plan
- SIZE=4, load A beats {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} (B identical), no stalls -> o_clear one cycle. Then at t=0 lanes = {1,0,0,0}, t=1 {5,2,0,0}, t=3 {13,10,7,4}, t=6 {0,0,0,16}. o_done 13 cycles after the last beat.
- Same data with i_valid toggling 1,0,1,0 -> identical output sequence, starting 1 cycle after the 4th accepted beat.
- Assert i_valid with distinct data throughout STREAM -> o_ready=0, outputs unchanged, buffers not overwritten, next run starts only after o_done.
- Assert i_reset mid-STREAM at t=2 -> all outputs 0 in the same cycle, o_ready=1 after release, no o_done, a fresh load works correctly.
- Build without SYSTOLIC_SKEWER_DRAIN_EN -> o_done 9 cycles after the last beat, o_stream_valid high exactly 7 cycles.
- End-to-end with the array: A, B of all 255 -> every array output 4*255*255 = 260100 after o_done.

Source files
------------

// File: rtl/systolic_input_skewer_pkg.sv
// -----------------------------------------------------------------------------
// systolic_input_skewer_pkg
// Shared definitions for the systolic input skewer: FSM state encoding and
// the run-length helpers (wavefront stream length and drain length) as a
// function of the array dimension.
// -----------------------------------------------------------------------------
package systolic_input_skewer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } skew_state_t;

  // A full diagonal wavefront over SIZE lanes lasts 2*SIZE-1 steps.
  function automatic int stream_len(input int size);
    return 2 * size - 1;
  endfunction

  // Zero cycles needed for the last wavefront to ripple through the array.
  function automatic int drain_len(input int size);
    return size;
  endfunction

endpackage

// File: rtl/systolic_input_skewer_lane_select.sv
// -----------------------------------------------------------------------------
// systolic_lane_select
// Window selector for one skewed lane. Lane LANE shows buffered beat
// d = step - LANE when 0 <= d < SIZE, otherwise zero.
// Ports:
//   step   : current wavefront step
//   col_a  : column LANE of the A buffer, beat j at [j*I_BITS +: I_BITS]
//   col_b  : column LANE of the B buffer, same packing
//   lane_a : selected A element (or 0)
//   lane_b : selected B element (or 0)
// -----------------------------------------------------------------------------
module systolic_lane_select #(
  parameter int SIZE   = 4,
  parameter int I_BITS = 8,
  parameter int LANE   = 0,
  parameter int CNT_W  = 3
) (
  input  logic [CNT_W-1:0]       step,
  input  logic [SIZE*I_BITS-1:0] col_a,
  input  logic [SIZE*I_BITS-1:0] col_b,
  output logic [I_BITS-1:0]      lane_a,
  output logic [I_BITS-1:0]      lane_b
);

  // Matching step against every legal beat keeps all part-selects constant
  // and makes out-of-window steps fall through to zero naturally.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (int'(step) == j + LANE) begin
        lane_a = col_a[j*I_BITS +: I_BITS];
        lane_b = col_b[j*I_BITS +: I_BITS];
      end
    end
  end

endmodule

// File: rtl/systolic_input_skewer.sv
// -----------------------------------------------------------------------------
// systolic_input_skewer
// Feeder for a SIZE x SIZE systolic array. Collects SIZE A/B vector pairs over
// valid/ready, then emits a one-cycle clear pulse, a diagonal wavefront (lane k
// delayed k cycles, zero outside its window), an optional all-zero drain, and
// a one-cycle done pulse.
// Build option: define SYSTOLIC_SKEWER_DRAIN_EN to include the SIZE-cycle
// drain phase; without it the stream goes straight to done.
// Ports:
//   i_clock, i_reset       : clock, asynchronous active-high reset
//   i_valid / o_ready      : input beat handshake
//   i_a_vec, i_b_vec       : operand vectors, element k at [k*I_BITS +: I_BITS]
//   o_a_full, o_b_full     : skewed lanes to the array (registered)
//   o_stream_valid         : wavefront/drain data present (registered)
//   o_clear                : one-cycle array clear pulse (registered)
//   o_done                 : one-cycle end-of-run pulse (registered)
// -----------------------------------------------------------------------------
module systolic_input_skewer
  import systolic_input_skewer_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int I_BITS = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [SIZE*I_BITS-1:0] i_a_vec,
  input  logic [SIZE*I_BITS-1:0] i_b_vec,
  output logic [SIZE*I_BITS-1:0] o_a_full,
  output logic [SIZE*I_BITS-1:0] o_b_full,
  output logic                   o_stream_valid,
  output logic                   o_clear,
  output logic                   o_done
);

  localparam int CNT_W      = $clog2(2 * SIZE);
  localparam int BEAT_W     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int STREAM_LEN = stream_len(SIZE);
  localparam int DRAIN_LEN  = drain_len(SIZE);

  skew_state_t             state;
  logic [CNT_W-1:0]        step;
  logic [BEAT_W-1:0]       beat;
  logic [SIZE*I_BITS-1:0]  buf_a [SIZE];
  logic [SIZE*I_BITS-1:0]  buf_b [SIZE];
  logic [SIZE*I_BITS-1:0]  lanes_a;
  logic [SIZE*I_BITS-1:0]  lanes_b;
  logic                    accept;

  // Ready is held low while reset is asserted so nothing is accepted then.
  assign o_ready = ~i_reset & ((state == ST_IDLE) | (state == ST_LOAD));
  assign accept  = i_valid & o_ready;

  // Control: FSM, beat index, step counter and operand buffers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      step  <= '0;
      beat  <= '0;
      for (int j = 0; j < SIZE; j++) begin
        buf_a[j] <= '0;
        buf_b[j] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            buf_a[beat] <= i_a_vec;
            buf_b[beat] <= i_b_vec;
            if (beat == BEAT_W'(SIZE - 1)) begin
              beat  <= '0;
              state <= ST_CLEAR;
            end else begin
              beat  <= beat + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        ST_CLEAR: begin
          step  <= '0;
          state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (step == CNT_W'(STREAM_LEN - 1)) begin
            step  <= '0;
`ifdef SYSTOLIC_SKEWER_DRAIN_EN
            state <= ST_DRAIN;
`else
            state <= ST_DONE;
`endif
          end else begin
            step <= step + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (step == CNT_W'(DRAIN_LEN - 1)) begin
            step  <= '0;
            state <= ST_DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-lane window selection over the transposed buffer columns
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [SIZE*I_BITS-1:0] col_a;
    logic [SIZE*I_BITS-1:0] col_b;
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      assign col_a[j*I_BITS +: I_BITS] = buf_a[j][k*I_BITS +: I_BITS];
      assign col_b[j*I_BITS +: I_BITS] = buf_b[j][k*I_BITS +: I_BITS];
    end
    systolic_lane_select #(
      .SIZE   (SIZE),
      .I_BITS (I_BITS),
      .LANE   (k),
      .CNT_W  (CNT_W)
    ) u_sel (
      .step   (step),
      .col_a  (col_a),
      .col_b  (col_b),
      .lane_a (lanes_a[k*I_BITS +: I_BITS]),
      .lane_b (lanes_b[k*I_BITS +: I_BITS])
    );
  end

  // Output register stage: outputs reflect the state one cycle later
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_a_full       <= '0;
      o_b_full       <= '0;
      o_stream_valid <= 1'b0;
      o_clear        <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_a_full       <= (state == ST_STREAM) ? lanes_a : '0;
      o_b_full       <= (state == ST_STREAM) ? lanes_b : '0;
      o_stream_valid <= (state == ST_STREAM) | (state == ST_DRAIN);
      o_clear        <= (state == ST_CLEAR);
      o_done         <= (state == ST_DONE);
    end
  end

endmodule
